// File: rtl/sweep_pkg.sv
// Shared types and default widths for the sweep sequencer.
// The DWELL state exists only when SWEEP_DWELL_EN is defined.
package sweep_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CYC_W = 4;
    localparam int DEF_DWL_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SEEK  = 3'd2;
    localparam logic [2:0] ST_UP    = 3'd3;
    localparam logic [2:0] ST_DOWN  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_DWELL = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR,
        S_SEEK  = ST_SEEK,
        S_UP    = ST_UP,
        S_DOWN  = ST_DOWN,
        S_DONE  = ST_DONE
`ifdef SWEEP_DWELL_EN
        ,
        S_DWELL = ST_DWELL
`endif
    } state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Load / decrement down-counter with a zero flag, used to time the hold at
// each turning point (instantiated only when SWEEP_DWELL_EN is defined).
module sweep_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] val;

    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
        end else if (load) begin
            val <= load_val;
        end else if (dec && (val != '0)) begin
            val <= val - 1'b1;
        end
    end

    assign zero = (val == '0);

endmodule

// File: rtl/sweep_controller.sv
// Drives an external up/down counter through clear, seek to lo, and lo/hi
// sweeps. Define SWEEP_DWELL_EN to add a programmable hold at turning points.
module sweep_controller
    import sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CYC_W = DEF_CYC_W,
    parameter int DWL_W = DEF_DWL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic [CYC_W-1:0] n_sweeps,
`ifdef SWEEP_DWELL_EN
    input  logic [DWL_W-1:0] dwell,
`endif
    input  logic [WIDTH-1:0] count,
    output logic             cnt_rst,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CYC_W-1:0] sweep_cnt
);

    if (WIDTH < 2 || CYC_W < 1 || DWL_W < 1) begin : g_param_chk
        $error("sweep_controller: widths must be positive (WIDTH >= 2)");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [CYC_W-1:0] n_q, sweep_q, sweep_inc;
    logic             up_q, err_q;
    logic             accept, illegal, sweep_step, finish;
    logic [WIDTH:0]   cnt_inc, cnt_dec;
    logic             at_hi, at_lo_seek, at_lo_down;

    // One bit of headroom keeps count+1 at the top and count-1 at zero from wrapping.
    assign cnt_inc    = {1'b0, count} + 1'b1;
    assign cnt_dec    = {1'b0, count} - 1'b1;
    assign at_hi      = (cnt_inc == {1'b0, hi_q});
    assign at_lo_seek = (cnt_inc == {1'b0, lo_q});
    assign at_lo_down = (cnt_dec == {1'b0, lo_q});
    assign sweep_inc  = sweep_q + 1'b1;
    assign finish     = (n_q != '0) && (sweep_inc == n_q);

`ifdef SWEEP_DWELL_EN
    logic dwell_zero, dwell_go;

    assign dwell_go = (dwell != '0);

    // Loaded with dwell-1 so DWELL lasts exactly `dwell` cycles.
    sweep_dwell_timer #(.W(DWL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_nxt == S_DWELL) && (state != S_DWELL)),
        .load_val (dwell - 1'b1),
        .dec      (state == S_DWELL),
        .zero     (dwell_zero)
    );
`endif

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        illegal    = 1'b0;
        sweep_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (lo_lim < hi_lim) begin
                        accept    = 1'b1;
                        state_nxt = S_CLEAR;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            S_CLEAR: state_nxt = (lo_q == '0) ? S_UP : S_SEEK;
            S_SEEK: begin
                if (at_lo_seek) state_nxt = S_UP;
            end
            S_UP: begin
                if (at_hi) begin
`ifdef SWEEP_DWELL_EN
                    state_nxt = dwell_go ? S_DWELL : S_DOWN;
`else
                    state_nxt = S_DOWN;
`endif
                end
            end
            S_DOWN: begin
                if (at_lo_down) begin
                    sweep_step = 1'b1;
                    if (finish) begin
                        state_nxt = S_DONE;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        state_nxt = dwell_go ? S_DWELL : S_UP;
`else
                        state_nxt = S_UP;
`endif
                    end
                end
            end
`ifdef SWEEP_DWELL_EN
            S_DWELL: begin
                if (dwell_zero) state_nxt = up_q ? S_DOWN : S_UP;
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort leaves the sweep count as it was, even on a turning edge.
        if (abort && (state != S_IDLE)) begin
            state_nxt  = S_IDLE;
            sweep_step = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            n_q     <= '0;
            sweep_q <= '0;
            up_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= illegal;
            if (accept) begin
                lo_q    <= lo_lim;
                hi_q    <= hi_lim;
                n_q     <= n_sweeps;
                sweep_q <= '0;
            end else if (sweep_step) begin
                sweep_q <= sweep_inc;
            end
            // Direction is held outside SEEK/UP/DOWN so it survives dwell and abort.
            if (state_nxt == S_SEEK || state_nxt == S_UP) begin
                up_q <= 1'b1;
            end else if (state_nxt == S_DOWN) begin
                up_q <= 1'b0;
            end
        end
    end

    always_comb begin
        cnt_rst = (state == S_CLEAR);
        cnt_en  = (state == S_SEEK) || (state == S_UP) || (state == S_DOWN);
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
    end

    assign cnt_up    = up_q;
    assign err       = err_q;
    assign sweep_cnt = sweep_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Directed bench for sweep_controller driving a behavioural 8-bit up/down counter.
// Dwell scenario is built only when SWEEP_DWELL_EN is defined.
module tb_sweep_controller;

    logic       clk, rst, start, abort;
    logic [7:0] lo_lim, hi_lim, count;
    logic [3:0] n_sweeps, sweep_cnt;
    logic       cnt_rst, cnt_en, cnt_up, busy, done, err;
`ifdef SWEEP_DWELL_EN
    logic [3:0] dwell;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] n;
        bit         illegal;
        int         exp_edge;
        int         exp_sweep;
        int         exp_count;
    } vec_t;

    vec_t vecs [9];

    sweep_controller #(.WIDTH(8), .CYC_W(4), .DWL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .lo_lim    (lo_lim),
        .hi_lim    (hi_lim),
        .n_sweeps  (n_sweeps),
`ifdef SWEEP_DWELL_EN
        .dwell     (dwell),
`endif
        .count     (count),
        .cnt_rst   (cnt_rst),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt)
    );

    // The load: an 8-bit up/down counter reset by the system reset or cnt_rst.
    always_ff @(posedge clk) begin
        if (rst || cnt_rst) count <= '0;
        else if (cnt_en)    count <= cnt_up ? count + 8'd1 : count - 8'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Start a sequence at edge E0 and measure the edge after which done is seen.
    task automatic run_seq(input string nm, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [3:0] n, input int exp_edge, input int exp_sweep,
                           input int exp_count);
        int  k;
        bit  seen;
        lo_lim = lo; hi_lim = hi; n_sweeps = n; start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, ".busy"}, busy, 1);
        chk({nm, ".cnt_rst"}, cnt_rst, 1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 700) begin
            tick();
            k++;
            if (done) seen = 1'b1;
        end
        chk({nm, ".done_edge"}, seen ? k : -1, exp_edge);
        chk({nm, ".sweep_cnt"}, sweep_cnt, exp_sweep);
        chk({nm, ".count"}, count, exp_count);
        chk({nm, ".cnt_en_done"}, cnt_en, 0);
        tick();
        chk({nm, ".done_1cyc"}, done, 0);
        chk({nm, ".busy_end"}, busy, 0);
        chk({nm, ".hold"}, count, exp_count);
    endtask

    task automatic run_illegal(input string nm, input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] prev;
        prev = count;
        lo_lim = lo; hi_lim = hi; n_sweeps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, ".err"}, err, 1);
        chk({nm, ".busy"}, busy, 0);
        tick();
        chk({nm, ".err_1cyc"}, err, 0);
        chk({nm, ".busy2"}, busy, 0);
        chk({nm, ".count"}, count, prev);
    endtask

    initial begin
        int  exp_tr [9];
        bit  seen_done;
        int  k;

        vecs[0] = '{8'd2,   8'd5,   4'd1,  1'b0, 9,   1,  2};
        vecs[1] = '{8'd7,   8'd7,   4'd1,  1'b1, 0,   0,  0};
        vecs[2] = '{8'd0,   8'd4,   4'd2,  1'b0, 17,  2,  0};
        vecs[3] = '{8'd9,   8'd3,   4'd1,  1'b1, 0,   0,  0};
        vecs[4] = '{8'd3,   8'd4,   4'd3,  1'b0, 10,  3,  3};
        vecs[5] = '{8'd250, 8'd255, 4'd1,  1'b0, 261, 1,  250};
        vecs[6] = '{8'd0,   8'd1,   4'd2,  1'b0, 5,   2,  0};
        vecs[7] = '{8'd1,   8'd2,   4'd15, 1'b0, 32,  15, 1};
        vecs[8] = '{8'd0,   8'd255, 4'd1,  1'b0, 511, 1,  0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        lo_lim = '0; hi_lim = '0; n_sweeps = '0;
`ifdef SWEEP_DWELL_EN
        dwell = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst.cnt_rst", cnt_rst, 0);
        chk("rst.cnt_en", cnt_en, 0);
        chk("rst.cnt_up", cnt_up, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.sweep_cnt", sweep_cnt, 0);

        // Abort in IDLE does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort.busy", busy, 0);

        // Single sweep, traced count by count.
        exp_tr = '{0, 1, 2, 3, 4, 5, 4, 3, 2};
        lo_lim = 8'd2; hi_lim = 8'd5; n_sweeps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("trace.cnt_rst", cnt_rst, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("trace.count[E%0d]", i + 1), count, exp_tr[i]);
            chk($sformatf("trace.done[E%0d]", i + 1), done, (i == 8) ? 1 : 0);
        end
        chk("trace.sweep_cnt", sweep_cnt, 1);
        tick();
        chk("trace.idle", busy, 0);
        chk("trace.hold", count, 2);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].illegal)
                run_illegal($sformatf("vec%0d", v), vecs[v].lo, vecs[v].hi);
            else
                run_seq($sformatf("vec%0d", v), vecs[v].lo, vecs[v].hi, vecs[v].n,
                        vecs[v].exp_edge, vecs[v].exp_sweep, vecs[v].exp_count);
        end

        // Continuous mode, aborted at edge E40.
        lo_lim = 8'd0; hi_lim = 8'd3; n_sweeps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        seen_done = 1'b0;
        for (int i = 1; i < 40; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("cont.no_done", seen_done, 0);
        chk("cont.done", done, 0);
        chk("cont.cnt_en", cnt_en, 0);
        chk("cont.busy", busy, 0);
        chk("cont.sweep_cnt", sweep_cnt, 6);
        chk("cont.cnt_up", cnt_up, 1);
        chk("cont.count", count, 3);
        tick();
        tick();
        chk("cont.count_hold", count, 3);
        chk("cont.sweep_hold", sweep_cnt, 6);

        // Start and abort together in IDLE, then start/limit changes while busy.
        lo_lim = 8'd0; hi_lim = 8'd3; n_sweeps = 4'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa.busy", busy, 1);
        chk("sa.cnt_rst", cnt_rst, 1);
        tick();
        tick();
        lo_lim = 8'd1; hi_lim = 8'd9; n_sweeps = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("sa.count_E3", count, 2);
        chk("sa.busy_E3", busy, 1);
        k = 3;
        seen_done = 1'b0;
        while (!seen_done && k < 100) begin
            tick();
            k++;
            if (done) seen_done = 1'b1;
        end
        chk("sa.done_edge", seen_done ? k : -1, 7);
        chk("sa.sweep_cnt", sweep_cnt, 1);
        chk("sa.count", count, 0);
        tick();
        chk("sa.idle", busy, 0);

        // Reset during DOWN, then a fresh sequence.
        lo_lim = 8'd2; hi_lim = 8'd5; n_sweeps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid.cnt_up", cnt_up, 0);
        chk("mid.cnt_en", cnt_en, 1);
        chk("mid.count", count, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.busy", busy, 0);
        chk("rst2.cnt_en", cnt_en, 0);
        chk("rst2.cnt_up", cnt_up, 0);
        chk("rst2.cnt_rst", cnt_rst, 0);
        chk("rst2.sweep_cnt", sweep_cnt, 0);
        chk("rst2.count", count, 0);
        run_seq("post_rst", 8'd1, 8'd2, 4'd1, 4, 1, 1);

`ifdef SWEEP_DWELL_EN
        begin
            int exp_dw [8];
            int exp_en [8];
            exp_dw = '{0, 1, 2, 3, 3, 3, 2, 1};
            exp_en = '{1, 1, 1, 0, 0, 1, 1, 0};
            dwell = 4'd2;
            lo_lim = 8'd1; hi_lim = 8'd3; n_sweeps = 4'd1; start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                chk($sformatf("dwell.count[E%0d]", i + 1), count, exp_dw[i]);
                chk($sformatf("dwell.cnt_en[E%0d]", i + 1), cnt_en, exp_en[i]);
                chk($sformatf("dwell.done[E%0d]", i + 1), done, (i == 7) ? 1 : 0);
            end
            tick();
            chk("dwell.idle", busy, 0);
            dwell = 4'd0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
